// File: rtl/io_responder.sv
// io_responder: memory-mapped output peripheral with a byte transmit FIFO,
// a status/control register pair, and a free-running cycle counter.
// Register window (DataAddr[3:2]): 0 TXDATA, 1 STATUS, 2 CTRL, 3 TICKS.
module io_responder #(
   parameter int size  = 32,
   parameter int DEPTH = 8
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [size-1:0] DataAddr,
   input  logic [size-1:0] WriteData,
   input  logic            WET,
   output logic [size-1:0] ReadData,
   output logic [7:0]      out_data,
   output logic            out_valid,
   input  logic            out_ready
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic [1:0] {
      REG_TXDATA = 2'd0,
      REG_STATUS = 2'd1,
      REG_CTRL   = 2'd2,
      REG_TICKS  = 2'd3
   } reg_sel_e;

   logic [7:0]    mem_q [DEPTH];
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          ovf_q, ovf_d;
   logic [31:0]   ticks_q, ticks_d;

   reg_sel_e sel;
   logic     full, empty;
   logic     push, push_ok, pop;
   logic     ctrl_wr, flush, clr_ovf;

   // Address bits outside the register select and store bits above the byte
   // lane carry no meaning here; fold them so they are visibly consumed.
   logic unused_bits;
   assign unused_bits = ^{DataAddr[size-1:4], DataAddr[1:0], WriteData[size-1:8]};

   assign sel     = reg_sel_e'(DataAddr[3:2]);
   assign empty   = (count_q == '0);
   assign full    = (count_q == CW'(DEPTH));
   assign out_valid = !empty;
   assign out_data  = empty ? 8'h00 : mem_q[rd_ptr_q];

   assign push    = WET && (sel == REG_TXDATA);
   assign ctrl_wr = WET && (sel == REG_CTRL);
   assign flush   = ctrl_wr && WriteData[1];
   assign clr_ovf = ctrl_wr && WriteData[0];
   assign pop     = out_valid && out_ready;
   // A simultaneous pop frees a slot, so a push into a full FIFO still lands.
   assign push_ok = push && (!full || pop);

   // Next-state for FIFO pointers, count, sticky overflow and cycle counter.
   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      ovf_d    = ovf_q;
      ticks_d  = ticks_q + 32'd1;
      if (flush) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (pop)     rd_ptr_d = rd_ptr_q + 1'b1;
         if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
         count_d = count_q + CW'(push_ok) - CW'(pop);
      end
      if (clr_ovf) ovf_d = 1'b0;
      // Set is ordered after clear so it wins if both are ever requested.
      if (push && full && !pop) ovf_d = 1'b1;
   end

   // Control state register with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
         ticks_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
         ticks_q  <= ticks_d;
      end
   end

   // FIFO storage; contents are qualified by count so no reset is needed.
   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= WriteData[7:0];
   end

   // Combinational CPU read mux over the register window.
   always_comb begin
      ReadData = '0;
      unique case (sel)
         REG_TXDATA: ReadData[7:0] = out_data;
         REG_STATUS: begin
            ReadData[0]        = empty;
            ReadData[1]        = full;
            ReadData[2]        = ovf_q;
            ReadData[4+CW-1:4] = count_q;
         end
         REG_CTRL:   ReadData = '0;
         REG_TICKS:  ReadData = size'(ticks_q);
         default:    ReadData = '0;
      endcase
   end

endmodule

// File: tb/tb_io_responder.sv
// Directed self-checking bench for io_responder (DEPTH = 8).
module tb_io_responder;

   logic        clk;
   logic        reset;
   logic [31:0] DataAddr;
   logic [31:0] WriteData;
   logic        WET;
   logic [31:0] ReadData;
   logic [7:0]  out_data;
   logic        out_valid;
   logic        out_ready;

   int unsigned checks   = 0;
   int unsigned failures = 0;

   io_responder #(.size(32), .DEPTH(8)) dut (
      .clk       (clk),
      .reset     (reset),
      .DataAddr  (DataAddr),
      .WriteData (WriteData),
      .WET       (WET),
      .ReadData  (ReadData),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   initial clk = 1'b0;
   // Free-running 10 ns clock.
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic rd(input logic [31:0] addr, input logic [31:0] exp, input string tag);
      DataAddr = addr;
      #1;
      check(tag, ReadData, exp);
   endtask

   task automatic wr(input logic [31:0] addr, input logic [31:0] data);
      DataAddr  = addr;
      WriteData = data;
      WET       = 1'b1;
      tick();
      WET       = 1'b0;
   endtask

   initial begin
      reset     = 1'b1;
      DataAddr  = 32'h0000_1000;
      WriteData = '0;
      WET       = 1'b0;
      out_ready = 1'b0;
      tick();
      tick();
      reset = 1'b0;

      // Reset state and cycle counter
      rd(32'h0000_1004, 32'h0000_0001, "rst_status");
      rd(32'h0000_1000, 32'h0000_0000, "rst_txdata");
      check("rst_valid", {31'd0, out_valid}, 32'd0);
      check("rst_odata", {24'd0, out_data}, 32'd0);
      rd(32'h0000_100C, 32'd0, "ticks0");
      tick();
      rd(32'h0000_100C, 32'd1, "ticks1");
      tick();
      rd(32'h0000_100C, 32'd2, "ticks2");

      // Three pushes, then drain
      wr(32'h0000_1000, 32'hFFFF_FF41);
      wr(32'h0000_1000, 32'h0000_0042);
      wr(32'h0000_1000, 32'h0000_0043);
      rd(32'h0000_1004, 32'h0000_0030, "status_3");
      rd(32'h0000_1000, 32'h0000_0041, "peek_41");
      rd(32'h0000_1008, 32'h0000_0000, "ctrl_reads0");
      check("valid_3", {31'd0, out_valid}, 32'd1);
      out_ready = 1'b1;
      check("drain_41", {24'd0, out_data}, 32'h41);
      tick();
      check("drain_42", {24'd0, out_data}, 32'h42);
      tick();
      check("drain_43", {24'd0, out_data}, 32'h43);
      tick();
      check("drain_empty", {31'd0, out_valid}, 32'd0);
      out_ready = 1'b0;

      // Fill to full, then overflow
      for (int i = 0; i < 8; i++) wr(32'h0000_1000, 32'h10 + i);
      rd(32'h0000_1004, 32'h0000_0082, "status_full");
      wr(32'h0000_1000, 32'h0000_0099);
      rd(32'h0000_1004, 32'h0000_0086, "status_ovf");
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         check($sformatf("ovf_drain%0d", i), {24'd0, out_data}, 32'h10 + i);
         tick();
      end
      out_ready = 1'b0;
      check("ovf_drained", {31'd0, out_valid}, 32'd0);
      rd(32'h0000_1004, 32'h0000_0005, "status_empty_ovf");
      wr(32'h0000_1008, 32'h0000_0001);
      rd(32'h0000_1004, 32'h0000_0001, "status_clr");

      // Full FIFO with simultaneous push and pop
      for (int i = 0; i < 8; i++) wr(32'h0000_1000, 32'h20 + i);
      out_ready = 1'b1;
      check("pp_head", {24'd0, out_data}, 32'h20);
      wr(32'h0000_1000, 32'h0000_0055);
      out_ready = 1'b0;
      rd(32'h0000_1004, 32'h0000_0082, "pp_status");
      out_ready = 1'b1;
      for (int i = 1; i < 8; i++) begin
         check($sformatf("pp_drain%0d", i), {24'd0, out_data}, 32'h20 + i);
         tick();
      end
      check("pp_last55", {24'd0, out_data}, 32'h55);
      tick();
      out_ready = 1'b0;
      check("pp_empty", {31'd0, out_valid}, 32'd0);

      // Flush beats a coincident pop
      wr(32'h0000_1000, 32'h31);
      wr(32'h0000_1000, 32'h32);
      wr(32'h0000_1000, 32'h33);
      out_ready = 1'b1;
      wr(32'h0000_1008, 32'h0000_0002);
      out_ready = 1'b0;
      rd(32'h0000_1004, 32'h0000_0001, "flush_status");
      check("flush_valid", {31'd0, out_valid}, 32'd0);

      // Reset mid-operation, then alias-address write
      for (int i = 0; i < 5; i++) wr(32'h0000_1000, 32'h60 + i);
      rd(32'h0000_1004, 32'h0000_0050, "pre_rst_status");
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("rst2_valid", {31'd0, out_valid}, 32'd0);
      rd(32'h0000_1004, 32'h0000_0001, "rst2_status");
      rd(32'h0000_100C, 32'd0, "rst2_ticks");
      wr(32'h0000_2010, 32'h0000_0077);
      check("alias_valid", {31'd0, out_valid}, 32'd1);
      check("alias_data", {24'd0, out_data}, 32'h77);
      rd(32'h0000_1004, 32'h0000_0010, "alias_status");
      rd(32'h0000_F000, 32'h0000_0077, "alias_read");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/io_responder.md
# io_responder

Memory-mapped output peripheral that answers the processor data bus in the region at and above 0x1000, the region whose writes the address decoder enables with WET and whose reads it routes to the CPU with muxSelect = 2'b00. Store instructions push bytes into a transmit FIFO. A downstream consumer (display or serial driver) drains the FIFO through a valid/ready handshake. Load instructions read status, peek the head byte, or read a free-running cycle counter.

## Interface
Parameters:
- size, 32, data/address width
- DEPTH, 8, FIFO entries; power of two, 2..16
- CW, $clog2(DEPTH)+1, count width (derived, not overridable)

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high
- DataAddr  input  size  CPU data address
- WriteData  input  size  CPU store data
- WET  input  1  write enable from the address decoder (region ≥ 0x1000)
- ReadData  output  size  combinational read data for the CPU read mux
- out_data  output  8  FIFO head byte
- out_valid  output  1  FIFO non-empty
- out_ready  input  1  consumer accepts head byte this cycle

One clock. Reset is synchronous and active-high.

## Operation
- Register select is DataAddr[3:2]. DataAddr[1:0] and all bits above bit 3 are ignored, so the 16-byte window aliases across the whole region. Only WET qualifies writes.
- Offset 0x0, TXDATA:
  - Write pushes WriteData[7:0].
  - Read returns the head byte zero-extended, or 0 when empty. Reads never pop.
- Offset 0x4, STATUS (read-only; writes ignored):
  - bit0 = empty, bit1 = full, bit2 = overflow (sticky).
  - bits[4+CW-1:4] = count; all other bits 0.
- Offset 0x8, CTRL (write-only; reads return 0):
  - bit0 = 1 clears overflow.
  - bit1 = 1 flushes the FIFO (pointers and count to 0).
- Offset 0xC, TICKS (read-only): 32-bit cycle counter, +1 every cycle, wraps 0xFFFFFFFF→0.
- FIFO:
  - Circular buffer with rd_ptr and wr_ptr of $clog2(DEPTH) bits, wrapping mod DEPTH, plus a CW-bit count.
  - push = WET && offset 0x0.
  - pop = out_valid && out_ready.
- Push when full without a pop: byte dropped, overflow set, count unchanged.
- Push and pop together:
  - Not empty, including full: both take effect, count unchanged, no overflow.
  - Empty: out_valid = 0 so no pop occurs; push accepted, count → 1.
- Flush precedence:
  - A flush in the same cycle as a pop wins; count → 0.
  - A push cannot coincide with a flush, since there is one write per cycle.
- An overflow set and a CTRL clear never coincide for the same reason. If both were ever requested, set wins.
- out_data = storage[rd_ptr] when non-empty, else 8'h00. out_valid = (count != 0).

## Timing
- Reset values:
  - count, pointers, overflow, TICKS = 0.
  - out_valid = 0, out_data = 0.
  - ReadData = 0x00000001 at STATUS, 0 elsewhere. TICKS reads 0 in the first cycle after reset deasserts.
- Reset asserted mid-operation discards FIFO contents at that edge. Storage contents need no reset.
- Write latency: a push at edge N makes out_valid = 1 and updates STATUS from cycle N+1.
- Pop latency: the consumer samples out_data when out_valid && out_ready at an edge; the next head appears the following cycle.
- ReadData is purely combinational from DataAddr and current registered state (zero cycles), matching the single-cycle load path.
- Handshake rules:
  - out_data stays stable while out_valid && !out_ready.
  - out_valid never drops without a pop, flush, or reset.
- STATUS read in the same cycle as a push shows the pre-push state.

## Test plan
- Reset, then read 0x1004 → 0x00000001. Read 0x100C on consecutive cycles → 0, 1, 2. out_valid = 0.
- Write 0x41, 0x42, 0x43 to 0x1000 with out_ready = 0:
  - STATUS → 0x30.
  - Raise out_ready for 3 cycles → out_data sequence 0x41, 0x42, 0x43, then out_valid = 0.
- Push 8 bytes (DEPTH = 8) then a ninth (0x99) with out_ready = 0:
  - STATUS → 0x86 (count 8, full, overflow).
  - Drain → 8 original bytes, no 0x99.
  - Write CTRL = 1 → overflow bit 0.
- Full FIFO, push 0x55 with out_ready = 1 in the same cycle:
  - Count stays 8, no overflow.
  - 0x55 emerges last after wrap-around of wr_ptr.
- Push 3 bytes, write CTRL = 2 while out_ready = 1 → next cycle STATUS = 0x01, out_valid = 0.
- Assert reset with 5 bytes queued and out_ready = 0:
  - Next cycle out_valid = 0, STATUS = 0x01, TICKS = 0.
  - Write at alias address 0x2010 → pushes like 0x1000.
